// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks a program counter, reads instruction bytes
// from program memory over a req/ack handshake, and buffers them in a small
// prefetch FIFO presented to the control unit with a valid/ready handshake.
// Redirects flush the FIFO and restart fetching at the target address.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_target
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] drop_addr;
  logic                  capture_drop;

  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  push, pop;

  // All outputs come from registers or the FIFO head; DROP keeps the stale
  // in-flight address on the bus while the fetch PC may already be redirected.
  assign mem_req    = (state != IDLE);
  assign mem_addr   = (state == DROP) ? drop_addr : fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;

  // A redirect overrides both push and pop; acked data in REQ is kept otherwise.
  assign push = (state == REQ) && mem_ack && !pc_load;
  assign pop  = inst_valid && inst_ready && !pc_load;

  // Occupancy after this edge's push/pop/flush, used to decide whether to keep fetching.
  always_comb begin
    count_next = count;
    if (pc_load) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Next-state and fetch PC logic for the fetch handshake.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    capture_drop  = 1'b0;
    if (pc_load) begin
      fetch_pc_next = pc_target;
    end
    case (state)
      IDLE: begin
        if (!pc_load && (count < FULL)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (pc_load) begin
          if (!mem_ack) begin
            state_next   = DROP;
            capture_drop = 1'b1;
          end
        end else if (mem_ack) begin
          fetch_pc_next = fetch_pc + ADDR_WIDTH'(1);
          state_next    = (count_next < FULL) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, fetch PC and the address of a request being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (capture_drop) begin
        drop_addr <= fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (pc_load) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
